// File: rtl/div_arbiter.sv
// Four-way round-robin front end for one shared iterative divider.
// Captures the winner's operands, launches the divider and reports quotient/status with a done pulse.
module div_arbiter #(
   parameter int W       = 10,
   parameter int TIMEOUT = 64
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [3:0]     req,
   input  logic [4*W-1:0] a_in,
   input  logic [4*W-1:0] b_in,
   output logic [3:0]     gnt,
   output logic [3:0]     done,
   output logic [W-1:0]   q_out,
   output logic [1:0]     err,
   output logic           div_start,
   output logic [W-1:0]   div_a,
   output logic [W-1:0]   div_b,
   input  logic           div_busy,
   input  logic           div_valid,
   input  logic           div_ovf,
   input  logic [W-1:0]   div_q
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DONE, DRAIN} state_t;

   state_t          state_reg, state_next;
   logic [1:0]      ptr_reg, win_reg;
   logic [3:0]      gnt_reg;
   logic [W-1:0]    q_reg, div_a_reg, div_b_reg;
   logic [1:0]      err_reg;
   logic [CW-1:0]   cnt_reg;
   logic            ovf_reg, tmo_reg;

   logic [1:0]      sel, cand;
   logic            found;
   logic            ovf_any, run_idle, run_tmo;

   // First requester at or after the pointer, wrapping 3 -> 0.
   always_comb begin
      sel   = ptr_reg;
      cand  = ptr_reg;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cand = ptr_reg + 2'(i);
         if (!found && req[cand]) begin
            sel   = cand;
            found = 1'b1;
         end
      end
   end

   assign ovf_any  = ovf_reg | div_ovf;
   // The divider may not have raised busy yet in the first RUN cycle.
   assign run_idle = !div_busy && !div_valid && (cnt_reg != '0);
   assign run_tmo  = (cnt_reg == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:   if (found && !div_busy) state_next = LAUNCH;
         LAUNCH: state_next = RUN;
         RUN:    if (div_valid || run_idle || run_tmo) state_next = DONE;
         DONE:   state_next = tmo_reg ? DRAIN : IDLE;
         DRAIN:  if (!div_busy) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_reg   <= '0;
         win_reg   <= '0;
         gnt_reg   <= '0;
         q_reg     <= '0;
         err_reg   <= '0;
         div_a_reg <= '0;
         div_b_reg <= '0;
         cnt_reg   <= '0;
         ovf_reg   <= 1'b0;
         tmo_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (found && !div_busy) begin
                  win_reg   <= sel;
                  gnt_reg   <= 4'b0001 << sel;
                  div_a_reg <= a_in[sel*W +: W];
                  div_b_reg <= b_in[sel*W +: W];
               end
            end
            LAUNCH: begin
               cnt_reg <= '0;
               ovf_reg <= 1'b0;
               tmo_reg <= 1'b0;
            end
            RUN: begin
               cnt_reg <= cnt_reg + 1'b1;
               if (div_ovf) ovf_reg <= 1'b1;
               if (div_valid) begin
                  q_reg   <= div_q;
                  err_reg <= ovf_any ? 2'b10 : 2'b00;
               end else if (run_idle) begin
                  err_reg <= ovf_any ? 2'b10 : 2'b01;
               end else if (run_tmo) begin
                  err_reg <= 2'b11;
                  tmo_reg <= 1'b1;
               end
            end
            DONE: begin
               gnt_reg <= '0;
               ptr_reg <= win_reg + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign gnt       = gnt_reg;
   assign done      = (state_reg == DONE) ? gnt_reg : 4'b0000;
   assign div_start = (state_reg == LAUNCH);
   assign q_out     = q_reg;
   assign err       = err_reg;
   assign div_a     = div_a_reg;
   assign div_b     = div_b_reg;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: reactive divider model plus a queue of expected completions.
module tb_div_arbiter;

   localparam int W       = 10;
   localparam int TIMEOUT = 64;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [3:0]     req = '0;
   logic [4*W-1:0] a_in = '0;
   logic [4*W-1:0] b_in = '0;
   logic [3:0]     gnt, done;
   logic [W-1:0]   q_out;
   logic [1:0]     err;
   logic           div_start;
   logic [W-1:0]   div_a, div_b;
   logic           div_busy  = 1'b0;
   logic           div_valid = 1'b0;
   logic           div_ovf   = 1'b0;
   logic [W-1:0]   div_q     = '0;

   always #5 clk = ~clk;

   div_arbiter #(.W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
      .gnt(gnt), .done(done), .q_out(q_out), .err(err),
      .div_start(div_start), .div_a(div_a), .div_b(div_b),
      .div_busy(div_busy), .div_valid(div_valid), .div_ovf(div_ovf), .div_q(div_q)
   );

   typedef struct packed {
      logic [3:0]   oh;
      logic [W-1:0] q;
      logic [1:0]   err;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc = 0, start_cnt = 0, start_cyc = 0;
   bit   hang = 1'b0, ovf_mode = 1'b0;
   bit   mhang = 1'b0;
   int   mcnt = 0;
   logic [W-1:0] ma = '0, mb = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (div_start === 1'b1) begin
         start_cnt <= start_cnt + 1;
         start_cyc <= cyc;
      end
   end

   // Divider: 3 busy cycles then a valid pulse (no valid on b=0), or 100 busy cycles when hung.
   always @(negedge clk or posedge rst) begin
      if (rst) begin
         div_busy <= 1'b0; div_valid <= 1'b0; div_ovf <= 1'b0; mcnt <= 0; mhang <= 1'b0;
      end else begin
         div_valid <= 1'b0;
         div_ovf   <= 1'b0;
         if (div_start === 1'b1) begin
            div_busy <= 1'b1; mhang <= hang; mcnt <= hang ? 100 : 3; ma <= div_a; mb <= div_b;
         end else if (div_busy) begin
            mcnt <= mcnt - 1;
            if (ovf_mode && mcnt == 3) div_ovf <= 1'b1;
            if (mcnt == 1) begin
               div_busy <= 1'b0;
               if (!mhang && mb != 0) begin
                  div_valid <= 1'b1;
                  div_q     <= ma / mb;
               end
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_done(input int budget, output logic [3:0] d);
      d = '0;
      for (int i = 0; i < budget && d == 4'b0; i++) begin
         tick();
         if (done !== 4'b0) d = done;
      end
   endtask

   task automatic set_op(input int idx, input int a, input int b);
      a_in[idx*W +: W] = W'(a);
      b_in[idx*W +: W] = W'(b);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_checks++;
      if ({gnt, done, q_out, err, div_start, div_a, div_b} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got gnt=%b done=%b q=%0d err=%b start=%b a=%0d b=%0d want all 0",
                            gnt, done, q_out, err, div_start, div_a, div_b);
      end
      tick(); tick();
      rst = 1'b0;
      tick();
      $display("test_reset: outputs gnt=%b done=%b q=%0d err=%b", gnt, done, q_out, err);
   endtask

   task automatic test_round_robin();
      logic [3:0] d;
      exp_t e;
      set_op(0, 100, 7);
      set_op(2, 50, 5);
      sb.push_back('{4'b0001, W'(14), 2'b00});
      sb.push_back('{4'b0100, W'(10), 2'b00});
      sb.push_back('{4'b0001, W'(14), 2'b00});
      req = 4'b0101;
      for (int j = 0; j < 3; j++) begin
         wait_done(50, d);
         e = sb.pop_front();
         $display("test_round_robin[%0d]: done=%b gnt=%b q=%0d err=%b", j, d, gnt, q_out, err);
         n_checks++;
         if (d !== e.oh) begin n_fail++; $display("FAIL rr_done[%0d]: got %b want %b", j, d, e.oh); end
         n_checks++;
         if (gnt !== e.oh) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", j, gnt, e.oh); end
         n_checks++;
         if (q_out !== e.q || err !== e.err) begin
            n_fail++; $display("FAIL rr_result[%0d]: got q=%0d err=%b want q=%0d err=%b", j, q_out, err, e.q, e.err);
         end
         case (j)
            0:       req = 4'b0100;
            1:       req = 4'b0101;
            default: req = 4'b0000;
         endcase
      end
      tick();
   endtask

   task automatic test_basic();
      logic [3:0] d;
      exp_t e;
      int s;
      tick();
      set_op(0, 100, 7);
      s = start_cnt;
      sb.push_back('{4'b0001, W'(14), 2'b00});
      req = 4'b0001;
      tick();
      n_checks++;
      if (div_start !== 1'b1) begin n_fail++; $display("FAIL basic_start_latency: got %b want 1", div_start); end
      n_checks++;
      if (div_a !== W'(100) || div_b !== W'(7)) begin
         n_fail++; $display("FAIL basic_operands: got a=%0d b=%0d want a=100 b=7", div_a, div_b);
      end
      // Requester lets go and scribbles its operands while the job runs.
      req = 4'b0000;
      set_op(0, 999, 1);
      tick();
      n_checks++;
      if (div_start !== 1'b0) begin n_fail++; $display("FAIL basic_start_width: got %b want 0", div_start); end
      wait_done(20, d);
      e = sb.pop_front();
      $display("test_basic: done=%b q=%0d err=%b cycles=%0d", d, q_out, err, cyc - start_cyc);
      n_checks++;
      if (d !== e.oh) begin n_fail++; $display("FAIL basic_done: got %b want %b", d, e.oh); end
      n_checks++;
      if (q_out !== e.q || err !== e.err) begin
         n_fail++; $display("FAIL basic_result: got q=%0d err=%b want q=%0d err=%b", q_out, err, e.q, e.err);
      end
      n_checks++;
      if (cyc - start_cyc !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d want 4", cyc - start_cyc); end
      tick();
      n_checks++;
      if (done !== 4'b0 || gnt !== 4'b0) begin
         n_fail++; $display("FAIL basic_pulse_end: got done=%b gnt=%b want 0000 0000", done, gnt);
      end
      n_checks++;
      if (start_cnt !== s + 1) begin n_fail++; $display("FAIL basic_start_count: got %0d want %0d", start_cnt - s, 1); end
   endtask

   task automatic test_div_zero();
      logic [3:0] d;
      exp_t e;
      set_op(1, 33, 0);
      sb.push_back('{4'b0010, W'(14), 2'b01});
      req = 4'b0010;
      wait_done(20, d);
      req = 4'b0000;
      e = sb.pop_front();
      $display("test_div_zero: done=%b q=%0d err=%b", d, q_out, err);
      n_checks++;
      if (d !== e.oh) begin n_fail++; $display("FAIL dz_done: got %b want %b", d, e.oh); end
      n_checks++;
      if (q_out !== e.q || err !== e.err) begin
         n_fail++; $display("FAIL dz_result: got q=%0d err=%b want q=%0d err=%b", q_out, err, e.q, e.err);
      end
      tick();
   endtask

   task automatic test_overflow();
      logic [3:0] d;
      exp_t e;
      ovf_mode = 1'b1;
      set_op(1, 200, 3);
      set_op(0, 45, 9);
      sb.push_back('{4'b0010, W'(66), 2'b10});
      sb.push_back('{4'b0001, W'(5), 2'b00});
      req = 4'b0010;
      for (int j = 0; j < 2; j++) begin
         wait_done(20, d);
         e = sb.pop_front();
         $display("test_overflow[%0d]: done=%b q=%0d err=%b", j, d, q_out, err);
         n_checks++;
         if (d !== e.oh) begin n_fail++; $display("FAIL ovf_done[%0d]: got %b want %b", j, d, e.oh); end
         n_checks++;
         if (q_out !== e.q || err !== e.err) begin
            n_fail++; $display("FAIL ovf_result[%0d]: got q=%0d err=%b want q=%0d err=%b", j, q_out, err, e.q, e.err);
         end
         ovf_mode = 1'b0;
         req = (j == 0) ? 4'b0001 : 4'b0000;
      end
      tick();
   endtask

   task automatic test_timeout();
      logic [3:0] d;
      exp_t e;
      int t0, s;
      hang = 1'b1;
      set_op(2, 50, 5);
      sb.push_back('{4'b0100, W'(5), 2'b11});
      req = 4'b0100;
      wait_done(100, d);
      e = sb.pop_front();
      t0 = start_cyc;
      $display("test_timeout: done=%b q=%0d err=%b run_cycles=%0d", d, q_out, err, cyc - start_cyc - 1);
      n_checks++;
      if (d !== e.oh) begin n_fail++; $display("FAIL to_done: got %b want %b", d, e.oh); end
      n_checks++;
      if (q_out !== e.q || err !== e.err) begin
         n_fail++; $display("FAIL to_result: got q=%0d err=%b want q=%0d err=%b", q_out, err, e.q, e.err);
      end
      n_checks++;
      if (cyc - start_cyc !== TIMEOUT + 1) begin
         n_fail++; $display("FAIL to_run_cycles: got %0d want %0d", cyc - start_cyc - 1, TIMEOUT);
      end
      // A new request arrives while the divider is still busy; it must wait for the drain.
      hang = 1'b0;
      set_op(0, 100, 7);
      sb.push_back('{4'b0001, W'(14), 2'b00});
      req = 4'b0001;
      s = start_cnt;
      for (int i = 0; i < 150 && start_cnt == s; i++) tick();
      n_checks++;
      if (start_cyc - t0 !== 102) begin
         n_fail++; $display("FAIL to_drain_start: got start %0d cycles after launch want 102", start_cyc - t0);
      end
      wait_done(20, d);
      req = 4'b0000;
      e = sb.pop_front();
      $display("test_timeout_next: done=%b q=%0d err=%b", d, q_out, err);
      n_checks++;
      if (d !== e.oh || q_out !== e.q || err !== e.err) begin
         n_fail++; $display("FAIL to_next_job: got done=%b q=%0d err=%b want done=%b q=%0d err=%b",
                            d, q_out, err, e.oh, e.q, e.err);
      end
      tick();
   endtask

   task automatic test_reset_midrun();
      logic [3:0] d;
      exp_t e;
      int s;
      hang = 1'b1;
      set_op(0, 100, 7);
      s = start_cnt;
      req = 4'b0001;
      for (int i = 0; i < 10 && start_cnt == s; i++) tick();
      for (int i = 0; i < 10; i++) tick();
      n_checks++;
      if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rm_running: got gnt=%b want 0001", gnt); end
      #1 rst = 1'b1;
      #1;
      $display("test_reset_midrun: after rst gnt=%b q=%0d a=%0d", gnt, q_out, div_a);
      n_checks++;
      if ({gnt, done, q_out, err, div_start, div_a, div_b} !== '0) begin
         n_fail++; $display("FAIL rm_async_clear: got gnt=%b done=%b q=%0d err=%b start=%b a=%0d b=%0d want all 0",
                            gnt, done, q_out, err, div_start, div_a, div_b);
      end
      tick();
      rst  = 1'b0;
      hang = 1'b0;
      set_op(3, 90, 9);
      sb.push_back('{4'b0001, W'(14), 2'b00});
      sb.push_back('{4'b1000, W'(10), 2'b00});
      req = 4'b1001;
      for (int j = 0; j < 2; j++) begin
         wait_done(20, d);
         e = sb.pop_front();
         $display("test_reset_midrun[%0d]: done=%b q=%0d err=%b", j, d, q_out, err);
         n_checks++;
         if (d !== e.oh) begin n_fail++; $display("FAIL rm_done[%0d]: got %b want %b", j, d, e.oh); end
         n_checks++;
         if (q_out !== e.q || err !== e.err) begin
            n_fail++; $display("FAIL rm_result[%0d]: got q=%0d err=%b want q=%0d err=%b", j, q_out, err, e.q, e.err);
         end
         req = (j == 0) ? 4'b1000 : 4'b0000;
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_basic();
      test_div_zero();
      test_overflow();
      test_timeout();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
